// File: rtl/rs_decode_scheduler_if.sv
// Requester and consumer valid/ready bundle for rs_decode_scheduler.
// slave = scheduler view, master = requester/consumer view.
interface rs_decode_scheduler_if #(
  parameter int N            = 18,
  parameter int SYMBOL_WIDTH = 5
);
  localparam int CW = N * SYMBOL_WIDTH;

  logic          req0_valid;
  logic          req0_ready;
  logic [CW-1:0] req0_data;
  logic          req1_valid;
  logic          req1_ready;
  logic [CW-1:0] req1_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_data;
  logic          out_id;
  logic          out_corrected;

  modport slave (
    input  req0_valid,
    input  req0_data,
    output req0_ready,
    input  req1_valid,
    input  req1_data,
    output req1_ready,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_id,
    output out_corrected
  );

  modport master (
    output req0_valid,
    output req0_data,
    input  req0_ready,
    output req1_valid,
    output req1_data,
    input  req1_ready,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_id,
    input  out_corrected
  );
endinterface

// File: rtl/rs_decode_scheduler.sv
// Round-robin share of one single-error RS decoder between two requesters.
// Optional RS_DEC_STATS_EN adds stat_total / stat_fixed delivery counters.
module rs_decode_scheduler #(
  parameter int N            = 18,
  parameter int SYMBOL_WIDTH = 5,
  parameter logic [SYMBOL_WIDTH-1:0] PRIM_POLY = 'h05
) (
  input  logic clk,
  input  logic rst,
  rs_decode_scheduler_if.slave bus,
  output logic busy
`ifdef RS_DEC_STATS_EN
  ,
  output logic [15:0] stat_total,
  output logic [15:0] stat_fixed
`endif
);
  localparam int W  = SYMBOL_WIDTH;
  localparam int CW = N * W;

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    OUTPUT
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cw_reg, cw_d;
  logic          id_reg, id_d;
  logic          last_grant, lg_d;
  logic          out_valid, ov_d;
  logic [CW-1:0] out_data, od_d;
  logic          out_id, oid_d;
  logic          out_corrected, oc_d;

  // GF(2^W) multiply, polynomial x^W + PRIM_POLY
  function automatic logic [W-1:0] gf_mul(
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    logic [W-1:0] p;
    logic [W-1:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < W; i++) begin
      if (b[i]) p = p ^ x;
      x = x[W-1] ? ((x << 1) ^ PRIM_POLY) : (x << 1);
    end
    return p;
  endfunction

  logic [W-1:0]  s0, s1, apow, bpow;
  logic [CW-1:0] dec_out;

  // S0 = error value, S1 = error value * alpha^position
  always_comb begin
    s0   = '0;
    s1   = '0;
    apow = W'(1);
    for (int i = 0; i < N; i++) begin
      s0   = s0 ^ cw_reg[i*W +: W];
      s1   = s1 ^ gf_mul(cw_reg[i*W +: W], apow);
      apow = gf_mul(apow, W'(2));
    end
  end

  always_comb begin
    dec_out = cw_reg;
    bpow    = W'(1);
    for (int i = 0; i < N; i++) begin
      if (s0 != '0 && s1 == gf_mul(s0, bpow))
        dec_out[i*W +: W] = cw_reg[i*W +: W] ^ s0;
      bpow = gf_mul(bpow, W'(2));
    end
  end

  logic grant;
  logic accept_window;
  logic hs;

  always_comb begin
    grant = ~last_grant;
    unique case (1'b1)
      (bus.req0_valid && !bus.req1_valid): grant = 1'b0;
      (bus.req1_valid && !bus.req0_valid): grant = 1'b1;
      default:                             grant = ~last_grant;
    endcase
  end

  assign accept_window = (state == IDLE) ||
                         (state == OUTPUT && bus.out_ready);
  assign bus.req0_ready = !rst && accept_window &&
                          !grant && bus.req0_valid;
  assign bus.req1_ready = !rst && accept_window &&
                          grant && bus.req1_valid;
  assign hs = bus.req0_ready | bus.req1_ready;

  always_comb begin
    state_d = state;
    cw_d    = cw_reg;
    id_d    = id_reg;
    lg_d    = last_grant;
    ov_d    = out_valid;
    od_d    = out_data;
    oid_d   = out_id;
    oc_d    = out_corrected;
    unique case (state)
      IDLE: begin
        if (hs) begin
          cw_d    = grant ? bus.req1_data : bus.req0_data;
          id_d    = grant;
          lg_d    = grant;
          state_d = DECODE;
        end
      end
      DECODE: begin
        od_d    = dec_out;
        oc_d    = (dec_out != cw_reg);
        oid_d   = id_reg;
        ov_d    = 1'b1;
        state_d = OUTPUT;
      end
      OUTPUT: begin
        if (bus.out_ready) begin
          ov_d = 1'b0;
          if (hs) begin
            cw_d    = grant ? bus.req1_data : bus.req0_data;
            id_d    = grant;
            lg_d    = grant;
            state_d = DECODE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cw_reg        <= '0;
      id_reg        <= 1'b0;
      last_grant    <= 1'b1;
      out_valid     <= 1'b0;
      out_data      <= '0;
      out_id        <= 1'b0;
      out_corrected <= 1'b0;
    end else begin
      state         <= state_d;
      cw_reg        <= cw_d;
      id_reg        <= id_d;
      last_grant    <= lg_d;
      out_valid     <= ov_d;
      out_data      <= od_d;
      out_id        <= oid_d;
      out_corrected <= oc_d;
    end
  end

  assign bus.out_valid     = out_valid;
  assign bus.out_data      = out_data;
  assign bus.out_id        = out_id;
  assign bus.out_corrected = out_corrected;
  assign busy              = (state != IDLE);

`ifdef RS_DEC_STATS_EN
  logic out_hs;
  assign out_hs = out_valid & bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_total <= '0;
      stat_fixed <= '0;
    end else if (out_hs) begin
      if (stat_total != 16'hFFFF)
        stat_total <= stat_total + 16'd1;
      if (out_corrected && stat_fixed != 16'hFFFF)
        stat_fixed <= stat_fixed + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rs_decode_scheduler.sv
// Bench for rs_decode_scheduler: directed steps plus a randomized
// phase scored against a log-table GF(32) reference decoder.
module tb_rs_decode_scheduler;
  localparam int N  = 18;
  localparam int SW = 5;
  localparam int CW = N * SW;

  logic clk = 1'b0;
  logic rst;
  logic busy;
`ifdef RS_DEC_STATS_EN
  logic [15:0] stat_total;
  logic [15:0] stat_fixed;
`endif

  rs_decode_scheduler_if #(.N(N), .SYMBOL_WIDTH(SW)) ifc ();

  rs_decode_scheduler #(.N(N), .SYMBOL_WIDTH(SW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (ifc.slave),
    .busy       (busy)
`ifdef RS_DEC_STATS_EN
    ,
    .stat_total (stat_total),
    .stat_fixed (stat_fixed)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_t[31];
  int log_t[32];

  logic [CW-1:0] q_data[$];
  bit            q_id[$];
  bit            q_corr[$];

  task automatic check(input string tag, input logic [CW-1:0] obs,
                       input logic [CW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference: syndromes via log/antilog, error position from log ratio
  function automatic logic [CW-1:0] model(input logic [CW-1:0] cw);
    int s0, s1, c, j;
    logic [CW-1:0] r;
    r  = cw;
    s0 = 0;
    s1 = 0;
    for (int i = 0; i < N; i++) begin
      c  = int'(cw[i*SW +: SW]);
      s0 = s0 ^ c;
      if (c != 0) s1 = s1 ^ exp_t[(log_t[c] + i) % 31];
    end
    if (s0 != 0 && s1 != 0) begin
      j = (log_t[s1] - log_t[s0] + 31) % 31;
      if (j < N) r[j*SW +: SW] = r[j*SW +: SW] ^ SW'(s0);
    end
    return r;
  endfunction

  function automatic logic [CW-1:0] rand_cw();
    logic [CW-1:0] r;
    for (int i = 0; i < N; i++) r[i*SW +: SW] = SW'($urandom);
    return r;
  endfunction

  function automatic logic [CW-1:0] clean_cw();
    logic [CW-1:0] r;
    r = rand_cw();
    for (int k = 0; k < 200 && model(r) == r; k++) r = rand_cw();
    return model(r);
  endfunction

  function automatic logic [CW-1:0] add_err(input logic [CW-1:0] cw);
    logic [CW-1:0] r;
    int p;
    r = cw;
    p = int'($urandom_range(0, N - 1));
    r[p*SW +: SW] = r[p*SW +: SW] ^ SW'($urandom_range(1, 31));
    return r;
  endfunction

  function automatic logic [CW-1:0] pick_cw();
    logic [CW-1:0] z;
    z = '0;
    case ($urandom % 4)
      0:       return rand_cw();
      1:       return clean_cw();
      2:       return add_err(clean_cw());
      default: return add_err(z);
    endcase
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    ifc.req0_valid = 1'b0;
    ifc.req1_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    q_data.delete();
    q_id.delete();
    q_corr.delete();
  endtask

  task automatic send_one(input bit id, input logic [CW-1:0] d);
    logic [CW-1:0] e;
    e = model(d);
    @(posedge clk); #1;
    ifc.out_ready  = 1'b1;
    ifc.req0_valid = !id;
    ifc.req1_valid = id;
    if (id) ifc.req1_data = d;
    else ifc.req0_data = d;
    @(negedge clk);
    check("own_ready", id ? ifc.req1_ready : ifc.req0_ready, 1);
    check("other_ready", id ? ifc.req0_ready : ifc.req1_ready, 0);
    @(posedge clk); #1;
    ifc.req0_valid = 1'b0;
    ifc.req1_valid = 1'b0;
    @(negedge clk);
    check("t1_out_valid", ifc.out_valid, 0);
    check("t1_busy", busy, 1);
    @(negedge clk);
    check("t2_out_valid", ifc.out_valid, 1);
    check("t2_out_data", ifc.out_data, e);
    check("t2_out_id", ifc.out_id, id);
    check("t2_out_corr", ifc.out_corrected, (e != d));
  endtask

  task automatic pop_check(input string tag);
    if (q_data.size() == 0) begin
      check({tag, "_unexpected_out"}, 1, 0);
    end else begin
      check({tag, "_data"}, ifc.out_data, q_data.pop_front());
      check({tag, "_id"}, ifc.out_id, q_id.pop_front());
      check({tag, "_corr"}, ifc.out_corrected, q_corr.pop_front());
    end
  endtask

  task automatic push_req(input bit id, input logic [CW-1:0] d);
    logic [CW-1:0] e;
    e = model(d);
    q_data.push_back(e);
    q_id.push_back(id);
    q_corr.push_back(e != d);
  endtask

  initial begin
    logic [CW-1:0] d, da, db, hold_data;
    bit hold_id, hold_corr, held;
    int ngrant, nout, last_out, cyc;

    begin
      int v;
      v = 1;
      for (int k = 0; k < 31; k++) begin
        exp_t[k] = v;
        log_t[v] = k;
        v = v << 1;
        if ((v & 32) != 0) v = v ^ 37;
      end
      log_t[0] = 0;
    end

    rst = 1'b1;
    ifc.req0_valid = 1'b1;
    ifc.req1_valid = 1'b1;
    ifc.req0_data  = '0;
    ifc.req1_data  = '0;
    ifc.out_ready  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req0_ready", ifc.req0_ready, 0);
    check("rst_req1_ready", ifc.req1_ready, 0);
    check("rst_out_valid", ifc.out_valid, 0);
    check("rst_out_data", ifc.out_data, 0);
    check("rst_out_id", ifc.out_id, 0);
    check("rst_out_corr", ifc.out_corrected, 0);
    check("rst_busy", busy, 0);
    @(posedge clk); #1;
    ifc.req0_valid = 1'b0;
    ifc.req1_valid = 1'b0;
    rst = 1'b0;

    d = '0;
    send_one(1'b0, d);
    d[3*SW +: SW] = 5'h0A;
    send_one(1'b1, d);
    send_one(1'b0, clean_cw());
    send_one(1'b1, add_err(clean_cw()));

    // Fairness: both valid continuously after reset
    do_reset();
    ifc.out_ready = 1'b1;
    ngrant = 0;
    nout = 0;
    last_out = -1;
    for (cyc = 0; cyc < 40 && nout < 6; cyc++) begin
      if (cyc != 0) begin
        @(posedge clk); #1;
      end
      ifc.req0_valid = 1'b1;
      ifc.req1_valid = 1'b1;
      ifc.req0_data  = pick_cw();
      ifc.req1_data  = pick_cw();
      @(negedge clk);
      check("fair_excl", ifc.req0_ready & ifc.req1_ready, 0);
      if (ifc.out_valid) begin
        if (last_out >= 0) check("fair_spacing", cyc - last_out, 2);
        last_out = cyc;
        pop_check("fair");
        nout++;
      end
      if (ifc.req0_ready || ifc.req1_ready) begin
        check("fair_order", ifc.req1_ready, ngrant % 2);
        push_req(ifc.req1_ready, ifc.req1_ready ? ifc.req1_data : ifc.req0_data);
        ngrant++;
      end
    end
    check("fair_outputs", nout, 6);

    // Back-pressure hold
    do_reset();
    da = pick_cw();
    db = pick_cw();
    ifc.out_ready  = 1'b0;
    ifc.req0_valid = 1'b1;
    ifc.req0_data  = da;
    @(negedge clk);
    check("bp_accept", ifc.req0_ready, 1);
    @(posedge clk); #1;
    ifc.req0_data  = db;
    ifc.req1_valid = 1'b1;
    ifc.req1_data  = pick_cw();
    @(negedge clk);
    check("bp_decode_ready", ifc.req0_ready | ifc.req1_ready, 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_valid", ifc.out_valid, 1);
      check("bp_data", ifc.out_data, model(da));
      check("bp_id", ifc.out_id, 0);
      check("bp_readies", {ifc.req0_ready, ifc.req1_ready}, 0);
    end
    @(posedge clk); #1;
    ifc.out_ready  = 1'b1;
    ifc.req1_valid = 1'b0;
    @(negedge clk);
    check("bp_same_cycle_accept", ifc.req0_ready, 1);
    check("bp_release_valid", ifc.out_valid, 1);
    @(posedge clk); #1;
    ifc.req0_valid = 1'b0;
    @(negedge clk);
    check("bp_next_t1", ifc.out_valid, 0);
    @(negedge clk);
    check("bp_next_t2", ifc.out_valid, 1);
    check("bp_next_data", ifc.out_data, model(db));
    check("bp_next_id", ifc.out_id, 0);

    // Reset while decoding
    @(posedge clk); #1;
    ifc.req1_valid = 1'b1;
    ifc.req1_data  = add_err(clean_cw());
    @(negedge clk);
    check("rd_accept", ifc.req1_ready, 1);
    @(posedge clk); #1;
    ifc.req1_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("rd_busy_decode", busy, 1);
    check("rd_no_ready", ifc.req0_ready | ifc.req1_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rd_busy", busy, 0);
    check("rd_out_valid", ifc.out_valid, 0);
    check("rd_out_data", ifc.out_data, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rd_never_out", ifc.out_valid, 0);
    end

    // Randomized traffic against the scoreboard
    do_reset();
    held = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      ifc.req0_valid = ($urandom % 3) != 0;
      ifc.req1_valid = ($urandom % 3) != 0;
      ifc.req0_data  = pick_cw();
      ifc.req1_data  = pick_cw();
      ifc.out_ready  = ($urandom % 4) != 0;
      @(negedge clk);
      check("rnd_excl", ifc.req0_ready & ifc.req1_ready, 0);
      check("rnd_r0_needs_v", ifc.req0_ready & !ifc.req0_valid, 0);
      check("rnd_r1_needs_v", ifc.req1_ready & !ifc.req1_valid, 0);
      if (held) begin
        check("rnd_hold_valid", ifc.out_valid, 1);
        check("rnd_hold_data", ifc.out_data, hold_data);
        check("rnd_hold_id", ifc.out_id, hold_id);
        check("rnd_hold_corr", ifc.out_corrected, hold_corr);
      end
      if (ifc.out_valid && ifc.out_ready) pop_check("rnd");
      if (ifc.req0_ready) push_req(1'b0, ifc.req0_data);
      if (ifc.req1_ready) push_req(1'b1, ifc.req1_data);
      held      = ifc.out_valid && !ifc.out_ready;
      hold_data = ifc.out_data;
      hold_id   = ifc.out_id;
      hold_corr = ifc.out_corrected;
    end
    @(posedge clk); #1;
    ifc.req0_valid = 1'b0;
    ifc.req1_valid = 1'b0;
    ifc.out_ready  = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (ifc.out_valid) pop_check("drain");
      @(posedge clk); #1;
    end
    check("drain_empty", q_data.size(), 0);

`ifdef RS_DEC_STATS_EN
    do_reset();
    @(negedge clk);
    check("stat_rst_total", stat_total, 0);
    for (int k = 0; k < 3; k++) send_one(k[0], clean_cw());
    for (int k = 0; k < 2; k++) send_one(k[0], add_err(clean_cw()));
    @(posedge clk); #1;
    @(negedge clk);
    check("stat_total", stat_total, 5);
    check("stat_fixed", stat_fixed, 2);
    do_reset();
    @(negedge clk);
    check("stat_clr_total", stat_total, 0);
    check("stat_clr_fixed", stat_fixed, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
